// File: rtl/pl_ddr_burst_writer.sv
// AXI4 write master: buffers a DATA_W-bit stream in a FIFO and writes it to
// DDR as INCR bursts that never cross a 4 KB page, one burst outstanding.
// Optional macro PL_DDR_WR_PERF_CNT_EN builds the busy-cycle counter that
// drives perf_cycles; without it perf_cycles is tied to zero.
module pl_ddr_burst_writer #(
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 40,
    parameter int DATA_W     = 256,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  ps_clk,
    input  logic                  ps_rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [31:0]           num_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           perf_cycles,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [ID_W-1:0]       m_awid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic [3:0]            m_awcache,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [ID_W-1:0]       m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    localparam int OFS_W = $clog2(DATA_W / 8);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         remaining_q;
    logic [31:0]         total_q;
    logic [31:0]         accepted_q;
    logic                error_q;
    logic [7:0]          beat_cnt_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic [31:0]         beats_to_4k;
    logic [31:0]         burst_len;
    logic [7:0]          len_m1;
    logic                start_acc;
    logic                push, pop;
    logic                unused_bid;

    assign unused_bid = ^m_bid;

    assign m_awid    = '0;
    assign m_awsize  = 3'(OFS_W);
    assign m_awburst = 2'b01;
    assign m_awcache = 4'b0011;
    assign m_awprot  = '0;
    assign m_wstrb   = '1;

    // Burst length: limited by MAX_BURST, beats left, and distance to the 4 KB page end
    always_comb begin
        beats_to_4k = (32'd4096 - {20'd0, addr_q[11:0]}) >> OFS_W;
        burst_len   = 32'(MAX_BURST);
        if (remaining_q < burst_len) burst_len = remaining_q;
        if (beats_to_4k < burst_len) burst_len = beats_to_4k;
        len_m1      = 8'(burst_len - 32'd1);
    end

    assign start_acc = start && (state_q == S_IDLE);
    assign error     = error_q;
    assign m_awaddr  = addr_q;
    assign push      = s_tvalid && s_tready;
    assign pop       = m_wvalid && m_wready;

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        s_tready  = 1'b0;
        m_awvalid = 1'b0;
        m_awlen   = '0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_wdata   = '0;
        m_bready  = 1'b0;
        if (state_q != S_IDLE && state_q != S_DONE) begin
            busy     = 1'b1;
            s_tready = (count_q != CNT_W'(FIFO_DEPTH)) && (accepted_q < total_q);
        end
        unique case (state_q)
            S_IDLE: if (start) state_d = (num_beats == 32'd0) ? S_DONE : S_WAIT;
            S_WAIT: if (32'(count_q) >= burst_len) state_d = S_ADDR;
            S_ADDR: begin
                m_awvalid = 1'b1;
                m_awlen   = len_m1;
                if (m_awready) state_d = S_DATA;
            end
            S_DATA: begin
                m_wvalid = (count_q != '0);
                m_wlast  = m_wvalid && (beat_cnt_q == len_m1);
                m_wdata  = m_wvalid ? mem_q[rd_ptr_q] : '0;
                if (m_wvalid && m_wready && m_wlast) state_d = S_RESP;
            end
            S_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_d = (remaining_q == burst_len) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Transfer bookkeeping: address, beat counters, sticky error
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            total_q     <= '0;
            accepted_q  <= '0;
            error_q     <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            if (start_acc) begin
                addr_q      <= base_addr & ~ADDR_W'(DATA_W / 8 - 1);
                remaining_q <= num_beats;
                total_q     <= num_beats;
                accepted_q  <= '0;
                error_q     <= 1'b0;
            end else if (push) begin
                accepted_q <= accepted_q + 32'd1;
            end
            if (pop) beat_cnt_q <= m_wlast ? 8'd0 : beat_cnt_q + 8'd1;
            if (state_q == S_RESP && m_bvalid) begin
                if (m_bresp != 2'b00) error_q <= 1'b1;
                addr_q      <= addr_q + (ADDR_W'(burst_len) << OFS_W);
                remaining_q <= remaining_q - burst_len;
            end
        end
    end

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge ps_clk) begin
        if (push) mem_q[wr_ptr_q] <= s_tdata;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

`ifdef PL_DDR_WR_PERF_CNT_EN
    logic [31:0] perf_q;

    // Busy-cycle counter, frozen from done until the next accepted start
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst)         perf_q <= '0;
        else if (start_acc) perf_q <= '0;
        else if (busy)      perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pl_ddr_burst_writer.sv
// Scoreboard bench for pl_ddr_burst_writer: stimulus pushes expected AW, W and
// completion records; a negedge monitor pops and compares on each handshake.
module tb_pl_ddr_burst_writer;

    logic          ps_clk = 1'b0;
    logic          ps_rst;
    logic          start;
    logic [39:0]   base_addr;
    logic [31:0]   num_beats;
    logic          busy, done, error;
    logic [31:0]   perf_cycles;
    logic [255:0]  s_tdata;
    logic          s_tvalid, s_tready;
    logic [3:0]    m_awid;
    logic [39:0]   m_awaddr;
    logic [7:0]    m_awlen;
    logic [2:0]    m_awsize;
    logic [1:0]    m_awburst;
    logic [3:0]    m_awcache;
    logic [2:0]    m_awprot;
    logic          m_awvalid, m_awready;
    logic [255:0]  m_wdata;
    logic [31:0]   m_wstrb;
    logic          m_wlast, m_wvalid, m_wready;
    logic [3:0]    m_bid;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;

    always #2 ps_clk = ~ps_clk;

    pl_ddr_burst_writer #(
        .ID_W(4), .ADDR_W(40), .DATA_W(256), .MAX_BURST(16), .FIFO_DEPTH(32)
    ) dut (
        .ps_clk(ps_clk), .ps_rst(ps_rst), .start(start), .base_addr(base_addr),
        .num_beats(num_beats), .busy(busy), .done(done), .error(error),
        .perf_cycles(perf_cycles), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    typedef struct { logic [39:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [255:0] data; logic last; } w_t;

    aw_t           exp_aw[$];
    w_t            exp_w[$];
    logic          exp_done[$];
    logic [255:0]  stream_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int data_ctr = 0;
    int bp       = 0;
    int err_idx  = -1;
    int wr_stall = 0;
    int burst_idx = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int n);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(n) * 32'h0100_0193 ^ 32'(i * 32'h1111);
        return d;
    endfunction

    task automatic push_burst(input logic [39:0] addr, input logic [7:0] len);
        logic [255:0] d;
        exp_aw.push_back('{addr, len});
        for (int i = 0; i <= int'(len); i++) begin
            d = mk(data_ctr);
            data_ctr++;
            stream_q.push_back(d);
            exp_w.push_back('{d, (i == int'(len))});
        end
    endtask

    task automatic start_xfer(input logic [39:0] a, input logic [31:0] n);
        @(posedge ps_clk); #1;
        base_addr = a; num_beats = n; start = 1'b1;
        @(posedge ps_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge ps_clk);
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, seen, 1'b1);
        check({name, "_aw_left"}, exp_aw.size(), 0);
        check({name, "_w_left"}, exp_w.size(), 0);
    endtask

    // Slave and stream driver: samples handshakes at negedge, updates after posedge
    initial begin : drv
        bit st_hs, wl_hs, b_hs, wv, start_smp;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
        s_tvalid = 0; s_tdata = '0;
        forever begin
            @(negedge ps_clk);
            st_hs     = s_tvalid && s_tready;
            wl_hs     = m_wvalid && m_wready && m_wlast;
            b_hs      = m_bvalid && m_bready;
            wv        = m_wvalid;
            start_smp = start && !busy;
            @(posedge ps_clk); #1;
            if (start_smp) burst_idx = 0;
            if (ps_rst) begin
                m_bvalid = 0; m_bresp = 0;
            end else begin
                if (st_hs && stream_q.size() > 0) void'(stream_q.pop_front());
                if (b_hs) m_bvalid = 0;
                if (wl_hs) begin
                    m_bvalid = 1;
                    m_bresp  = (burst_idx == err_idx) ? 2'b10 : 2'b00;
                    burst_idx++;
                end
                if (wv && wr_stall > 0) wr_stall--;
            end
            m_awready = bp != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready  = wr_stall > 0 ? 1'b0 : (bp != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
            s_tvalid  = stream_q.size() > 0 && (bp != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
            s_tdata   = stream_q.size() > 0 ? stream_q[0] : '0;
        end
    end

    // Monitor: pops expectations on AW, W and done events
    initial begin : mon
        int busy_cnt = 0, aw_cnt = 0, wb_done = 0;
        bit stall_prev = 0;
        logic [39:0] addr_prev;
        logic [7:0]  len_prev;
        aw_t a;
        w_t  w;
        forever begin
            @(negedge ps_clk);
            if (ps_rst) begin
                stall_prev = 0; aw_cnt = 0; wb_done = 0;
                continue;
            end
            if (start && !busy) busy_cnt = 0;
            if (busy) busy_cnt++;
            if (stall_prev) begin
                check("aw_stable", {m_awvalid, m_awaddr, m_awlen}, {1'b1, addr_prev, len_prev});
            end
            if (m_awvalid && m_awready) begin
                aw_cnt++;
                if (exp_aw.size() == 0) check("aw_unexpected", m_awaddr, '1);
                else begin
                    a = exp_aw.pop_front();
                    check("aw_addr", m_awaddr, a.addr);
                    check("aw_len", m_awlen, a.len);
                end
            end
            if (m_wvalid && m_wready) begin
                check("w_after_aw", aw_cnt > wb_done, 1'b1);
                if (exp_w.size() == 0) check("w_unexpected", m_wdata, '1);
                else begin
                    w = exp_w.pop_front();
                    check("w_data", m_wdata, w.data);
                    check("w_last", m_wlast, w.last);
                end
                if (m_wlast) wb_done++;
            end
            if (done) begin
                check("done_busy_low", busy, 1'b0);
                if (exp_done.size() == 0) check("done_unexpected", done, 1'b0);
                else check("done_error", error, exp_done.pop_front());
`ifdef PL_DDR_WR_PERF_CNT_EN
                check("perf_cycles", perf_cycles, busy_cnt);
`else
                check("perf_cycles", perf_cycles, 0);
`endif
            end
            stall_prev = m_awvalid && !m_awready;
            addr_prev  = m_awaddr;
            len_prev   = m_awlen;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        bit seen;
        ps_rst = 1; start = 0; base_addr = '0; num_beats = '0;
        repeat (3) @(posedge ps_clk);
        #1 ps_rst = 0;
        @(negedge ps_clk);
        check("reset_outs", {busy, done, error, s_tready, m_awvalid, m_wvalid, m_wlast,
                             m_bready, m_awlen, m_awaddr, perf_cycles}, '0);
        check("const_outs", {m_awid, m_awsize, m_awburst, m_awcache, m_awprot, m_wstrb},
              {4'd0, 3'd5, 2'b01, 4'b0011, 3'd0, 32'hFFFF_FFFF});

        // Basic burst with one surplus stream beat that must stay untaken
        push_burst(40'h1000, 8'd15);
        stream_q.push_back(mk(9999));
        exp_done.push_back(1'b0);
        start_xfer(40'h1000, 32'd16);
        @(negedge ps_clk);
        check("busy_after_start", busy, 1'b1);
        start_xfer(40'h5000, 32'd3);
        wait_done("basic", 2000);
        check("surplus_beat_kept", stream_q.size(), 1);
        stream_q.delete();

        // 4 KB split
        push_burst(40'h0FC0, 8'd1);
        push_burst(40'h1000, 8'd13);
        exp_done.push_back(1'b0);
        start_xfer(40'h0FC0, 32'd16);
        wait_done("split4k", 2000);

        // Remainder, low address bits ignored
        push_burst(40'h0, 8'd15);
        push_burst(40'h200, 8'd15);
        push_burst(40'h400, 8'd4);
        exp_done.push_back(1'b0);
        start_xfer(40'h1F, 32'd37);
        wait_done("remainder", 3000);

        // Address wrap at the top of the 40-bit space
        push_burst(40'hFF_FFFF_FFE0, 8'd0);
        push_burst(40'h0, 8'd0);
        exp_done.push_back(1'b0);
        start_xfer(40'hFF_FFFF_FFE0, 32'd2);
        wait_done("wrap", 1000);

        // Backpressure on all channels
        bp = 1;
        for (int i = 0; i < 6; i++) push_burst(40'h10000 + 40'(i * 32'h200), 8'd15);
        push_burst(40'h10C00, 8'd3);
        exp_done.push_back(1'b0);
        start_xfer(40'h10000, 32'd100);
        wait_done("backpressure", 10000);
        bp = 0;

        // SLVERR on the second burst
        err_idx = 1;
        push_burst(40'h2000, 8'd15);
        push_burst(40'h2200, 8'd15);
        push_burst(40'h2400, 8'd15);
        exp_done.push_back(1'b1);
        start_xfer(40'h2000, 32'd48);
        wait_done("slverr", 3000);
        check("error_sticky", error, 1'b1);
        err_idx = -1;

        // Zero length: no AW, error cleared, done one cycle after start
        exp_done.push_back(1'b0);
        start_xfer(40'h8000, 32'd0);
        @(negedge ps_clk);
        check("zero_done", {done, busy, error}, 3'b100);
        @(negedge ps_clk);
        check("zero_done_pulse", {done, busy}, 2'b00);

        // Write stall for perf counting
        wr_stall = 10;
        push_burst(40'h3000, 8'd15);
        exp_done.push_back(1'b0);
        start_xfer(40'h3000, 32'd16);
        wait_done("perf", 2000);
        repeat (3) @(negedge ps_clk);
`ifdef PL_DDR_WR_PERF_CNT_EN
        check("perf_hold_nonzero", perf_cycles > 32'd26, 1'b1);
`else
        check("perf_tied_zero", perf_cycles, 0);
`endif

        // Reset in the middle of DATA
        wr_stall = 40;
        push_burst(40'h4000, 8'd15);
        start_xfer(40'h4000, 32'd16);
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge ps_clk);
            if (m_wvalid) seen = 1;
        end
        check("reached_data", seen, 1'b1);
        @(posedge ps_clk); #1;
        ps_rst = 1;
        @(negedge ps_clk);
        check("midreset_outs", {busy, done, error, s_tready, m_awvalid, m_wvalid, m_wlast,
                                m_bready, m_awlen, m_awaddr, m_wdata, perf_cycles}, '0);
        exp_aw.delete(); exp_w.delete(); exp_done.delete(); stream_q.delete();
        wr_stall = 0;
        repeat (2) @(posedge ps_clk);
        #1 ps_rst = 0;

        // Recovery after reset
        push_burst(40'h40, 8'd3);
        exp_done.push_back(1'b0);
        start_xfer(40'h40, 32'd4);
        wait_done("recovery", 1000);

        repeat (3) @(negedge ps_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pl_ddr_burst_writer.md
Name: pl_ddr_burst_writer

Overview:
- AXI4 write master that moves a 256-bit sample stream from the PL fabric into PL DDR4 through the S01 slave port of the block design.
- It uses the write channels of that port; the read channels are used by the existing PL read path.
- Input data is buffered in an internal FIFO, cut into INCR bursts that never cross a 4 KB boundary, and sent with at most one burst outstanding.
- Software starts a transfer via registers in the AXI-Lite register block and sees busy/done/error back.

Parameters:
ID_W  4  AXI ID width
ADDR_W  40  AXI address width
DATA_W  256  AXI/stream data width; bytes per beat BPB = DATA_W/8 = 32
MAX_BURST  16  maximum beats per burst (1..128)
FIFO_DEPTH  32  input FIFO depth in beats, power of two, >= 2*MAX_BURST

Ports:
ps_clk  in  1  single clock, 333.25 MHz PS clock domain
ps_rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse, begins a transfer
base_addr  in  ADDR_W  DDR byte address; bits [4:0] ignored (treated as 0)
num_beats  in  32  total beats to write
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at completion
error  out  1  sticky: some BRESP was not OKAY
perf_cycles  out  32  see Optional Feature
s_tdata  in  DATA_W  stream data
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready
m_awid/awaddr/awlen/awsize/awburst/awcache/awprot/awvalid  out  ID_W/ADDR_W/8/3/2/4/3/1  AW channel
m_awready  in  1
m_wdata/wstrb/wlast/wvalid  out  DATA_W/BPB/1/1  W channel
m_wready  in  1
m_bid/bresp/bvalid  in  ID_W/2/1  B channel
m_bready  out  1

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, counters 0.
- Constant outputs: awid=0, awsize=5, awburst=INCR (2'b01), awcache=4'b0011, awprot=0, wstrb all ones.
- start is sampled only in IDLE; start while busy is ignored.
  - On an accepted start: latch the address (low 5 bits cleared) and remaining = num_beats; clear error; busy=1 on the next cycle.
  - If num_beats==0: no AXI traffic; done pulses 1 cycle after start; busy stays 0.
- s_tready = busy && FIFO not full && beats_accepted < num_beats. Beats beyond num_beats are never taken. Stream data is never dropped.
- Burst length L = min(MAX_BURST, remaining, beats_to_4k), where beats_to_4k = (4096 - addr[11:0])/32.
- FSM states:
  - IDLE: wait for start.
  - WAIT: wait until FIFO occupancy >= L, then go to ADDR.
  - ADDR: awvalid=1, awaddr=current addr, awlen=L-1. awvalid stays high, with stable fields, until awready; then go to DATA.
  - DATA: wvalid = FIFO not empty, wdata = FIFO head, wlast on beat L. After the wlast handshake, go to RESP.
  - RESP: bready=1. On bvalid: if bresp!=0, set error. Then addr += L*32 and remaining -= L. If remaining==0, go to DONE; otherwise go to WAIT.
  - DONE: done=1 for 1 cycle, busy drops in the same cycle, return to IDLE.
- W is never issued before the AW handshake; this FIFO-ahead-of-address scheme means W never waits on stream data mid-burst.
- An error does not abort the transfer; remaining bursts are still issued.
- FIFO write and read in the same cycle are allowed; occupancy stays the same.
- Address arithmetic is modulo 2^ADDR_W, with no saturation.
- Reset asserted mid-transfer: immediate return to the reset state. There is no AXI completion guarantee, so the bench must also reset the slave.

Optional Feature:
- Macro: PL_DDR_WR_PERF_CNT_EN.
- Defined: perf_cycles clears on an accepted start and increments every cycle while busy. It freezes on done and holds until the next start.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Basic burst: base_addr=0x1000, num_beats=16, stream always valid, slave always ready -> one AW (addr 0x1000, awlen 15); 16 W beats with wlast on the 16th; done pulses; error=0.
- 4 KB split: base_addr=0x0FC0, num_beats=16 -> bursts are (0x0FC0, awlen 1) then (0x1000, awlen 13); total 16 beats; data order preserved.
- Remainder: base_addr=0x0, num_beats=37, MAX_BURST=16 -> awlen 15, 15, 4 at 0x0, 0x200, 0x400; done after the third B.
- Backpressure: random awready/wready/s_tvalid at 50%, num_beats=100 -> memory model contents match the input sequence; awvalid and AW fields stay stable while stalled; no beats lost.
- Error and zero length: bresp=SLVERR on the 2nd burst of 48 beats -> all 3 bursts complete and error=1. Then start with num_beats=0 -> error clears, done 1 cycle later, no AW.
- Perf/reset: macro defined, 16 beats with wready low for 10 cycles -> perf_cycles equals the busy-cycle count. Assert ps_rst mid-DATA -> all outputs 0 on the next edge.
